// File: rtl/ncl_pkg.sv
// Shared dual-rail encoding helpers for the NCL control path.
package ncl_pkg;

  // Rail pair encoding is {t, f}.
  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;

  // True when the pair carries a legal DATA value (01 or 10).
  function automatic logic dr_is_data(input logic [1:0] pair);
    return (pair == DR_0) || (pair == DR_1);
  endfunction

  // True when both rails are low.
  function automatic logic dr_is_null(input logic [1:0] pair);
    return (pair == DR_NULL);
  endfunction

  // Boolean value of a DATA pair; only meaningful when dr_is_data() holds.
  function automatic logic dr_val(input logic [1:0] pair);
    return (pair == DR_1);
  endfunction

  // Encode a boolean onto a one-hot DATA pair.
  function automatic logic [1:0] dr_enc(input logic val);
    return val ? DR_1 : DR_0;
  endfunction

endpackage

// File: rtl/ncl_dr_reg.sv
// Two-rail register with NCL hysteresis: loads DATA only from NULL, returns to
// NULL only from DATA, and holds otherwise.
module ncl_dr_reg
  import ncl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic [1:0] set_val,
  input  logic       clr,
  output logic [1:0] q
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  // Next-state: DATA wavefront only from NULL, NULL wavefront only from DATA.
  always_comb begin
    state_d = state_q;
    if (dr_is_null(state_q)) begin
      // An illegal 11 set value is never loaded.
      if (set && dr_is_data(set_val)) begin
        state_d = set_val;
      end
    end else begin
      if (clr) begin
        state_d = DR_NULL;
      end
    end
  end

  // State register; synchronous reset wins over any wavefront.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DR_NULL;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/ncl_controller.sv
// Dual-rail control decoder: completion detection on PH0/PH1/Rd/Ld and
// registered R_c / R_m enables with NCL wavefront semantics.
module ncl_controller
  import ncl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic PH0_t,
  input  logic PH0_f,
  input  logic PH1_t,
  input  logic PH1_f,
  input  logic Rd_t,
  input  logic Rd_f,
  input  logic Ld_t,
  input  logic Ld_f,
  output logic R_c_t,
  output logic R_c_f,
  output logic R_m_t,
  output logic R_m_f
);

  logic [1:0] ph0, ph1, rd, ld;
  logic [1:0] rc_q, rm_q;
  logic       all_data, all_null;
  logic       out_null, out_data;
  logic       rc_val, rm_val;
  logic       set, clr;

  assign ph0 = {PH0_t, PH0_f};
  assign ph1 = {PH1_t, PH1_f};
  assign rd  = {Rd_t, Rd_f};
  assign ld  = {Ld_t, Ld_f};

  // Completion detection and the two control functions.
  always_comb begin
    all_data = dr_is_data(ph0) & dr_is_data(ph1) & dr_is_data(rd) & dr_is_data(ld);
    all_null = dr_is_null(ph0) & dr_is_null(ph1) & dr_is_null(rd) & dr_is_null(ld);
    rc_val   = dr_val(ph1) & ~dr_val(ph0) & dr_val(rd);
    rm_val   = dr_val(ph0) | (dr_val(ph1) & dr_val(ld));
  end

  // Gate both registers on the joint output phase so they always move together.
  always_comb begin
    out_null = dr_is_null(rc_q) & dr_is_null(rm_q);
    out_data = dr_is_data(rc_q) & dr_is_data(rm_q);
    set      = all_data & out_null;
    clr      = all_null & out_data;
  end

  ncl_dr_reg u_rc_reg (
    .clk     (clk),
    .rst     (rst),
    .set     (set),
    .set_val (dr_enc(rc_val)),
    .clr     (clr),
    .q       (rc_q)
  );

  ncl_dr_reg u_rm_reg (
    .clk     (clk),
    .rst     (rst),
    .set     (set),
    .set_val (dr_enc(rm_val)),
    .clr     (clr),
    .q       (rm_q)
  );

  assign R_c_t = rc_q[1];
  assign R_c_f = rc_q[0];
  assign R_m_t = rm_q[1];
  assign R_m_f = rm_q[0];

endmodule

// File: tb/tb_ncl_controller.sv
// Scoreboard bench for ncl_controller: stimulus pushes expected output
// wavefronts, a negedge monitor pops and checks them when the outputs change.
module tb_ncl_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f;
  logic R_c_t, R_c_f, R_m_t, R_m_f;

  typedef struct {
    logic [1:0]  rc;
    logic [1:0]  rm;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;

  ncl_controller dut (
    .clk   (clk),
    .rst   (rst),
    .PH0_t (PH0_t),
    .PH0_f (PH0_f),
    .PH1_t (PH1_t),
    .PH1_f (PH1_f),
    .Rd_t  (Rd_t),
    .Rd_f  (Rd_f),
    .Ld_t  (Ld_t),
    .Ld_f  (Ld_f),
    .R_c_t (R_c_t),
    .R_c_f (R_c_f),
    .R_m_t (R_m_t),
    .R_m_f (R_m_f)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic set_in(input logic [1:0] p0, input logic [1:0] p1,
                        input logic [1:0] r, input logic [1:0] l);
    {PH0_t, PH0_f} = p0;
    {PH1_t, PH1_f} = p1;
    {Rd_t, Rd_f}   = r;
    {Ld_t, Ld_f}   = l;
  endtask

  // Step to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output wavefront, due at the next rising edge.
  task automatic push_exp(input logic [1:0] rc, input logic [1:0] rm);
    exp_t e;
    e.rc  = rc;
    e.rm  = rm;
    e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Immediate level check, sampled on the falling edge.
  task automatic check_now(input string name, input logic [1:0] rc, input logic [1:0] rm);
    @(negedge clk);
    n_cmp++;
    if ({R_c_t, R_c_f, R_m_t, R_m_f} !== {rc, rm}) begin
      n_err++;
      $display("FAIL %s: got rc=%b rm=%b, want rc=%b rm=%b", name,
               {R_c_t, R_c_f}, {R_m_t, R_m_f}, rc, rm);
    end
  endtask

  // Monitor: never 11, and every output change must match the next expected wavefront.
  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    exp_t       e;
    prev = 4'b0000;
    forever begin
      @(negedge clk);
      cur = {R_c_t, R_c_f, R_m_t, R_m_f};
      if (mon_en) begin
        n_cmp++;
        if (cur[3:2] == 2'b11 || cur[1:0] == 2'b11) begin
          n_err++;
          $display("FAIL illegal_out: got %b, want no 11 pair", cur);
        end
        if (cur !== prev) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change: got %b from %b, want no change (cyc %0d)",
                     cur, prev, cyc);
          end else begin
            e = exp_q.pop_front();
            if (cur !== {e.rc, e.rm} || cyc != e.due) begin
              n_err++;
              $display("FAIL wavefront: got %b at cyc %0d, want %b at cyc %0d",
                       cur, cyc, {e.rc, e.rm}, e.due);
            end
          end
        end
      end
      prev = cur;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  localparam logic [1:0] N  = 2'b00;
  localparam logic [1:0] D0 = 2'b01;
  localparam logic [1:0] D1 = 2'b10;
  localparam logic [1:0] IL = 2'b11;

  initial begin
    // Hand-derived truth table, index = {PH0, PH1, Rd, Ld}.
    logic [15:0] rc_tab;
    logic [15:0] rm_tab;
    logic [3:0]  v;
    logic        out_data;
    rc_tab = 16'h00C0;  // only 0110, 0111
    rm_tab = 16'hFFA0;  // 1xxx plus 0101, 0111

    // Reset with DATA applied holds outputs NULL.
    set_in(D0, D1, D1, D0);
    repeat (3) @(posedge clk);
    check_now("reset_null", N, N);
    mon_en = 1'b1;

    // Release reset: DATA captured on the first clock with rst low.
    step();
    rst = 1'b0;
    push_exp(D1, D0);
    step();
    step();

    // NULL return.
    set_in(N, N, N, N);
    push_exp(N, N);
    step();
    step();
    out_data = 1'b0;

    // Exhaustive truth table, NULL between every DATA vector.
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      set_in(N, N, N, N);
      if (out_data) push_exp(N, N);
      step();
      set_in(v[3] ? D1 : D0, v[2] ? D1 : D0, v[1] ? D1 : D0, v[0] ? D1 : D0);
      push_exp(rc_tab[i] ? D1 : D0, rm_tab[i] ? D1 : D0);
      out_data = 1'b1;
      step();
    end

    // Partial wavefront holds NULL until the set completes.
    set_in(N, N, N, N);
    push_exp(N, N);
    step();
    set_in(D1, D0, N, N);
    step();
    step();
    check_now("partial_hold", N, N);
    #1;
    set_in(D1, D0, D0, D1);
    push_exp(D0, D1);
    step();
    step();

    // Hysteresis: DATA->DATA and partial NULL both hold.
    set_in(N, N, N, N);
    push_exp(N, N);
    step();
    set_in(D0, D1, D1, D0);
    push_exp(D1, D0);
    step();
    step();
    set_in(D0, D1, D0, D0);
    step();
    check_now("data_to_data_hold", D1, D0);
    #1;
    set_in(N, D1, N, D0);
    step();
    check_now("partial_null_hold", D1, D0);
    #1;

    // Illegal pair holds DATA, and blocks capture from NULL.
    set_in(D0, IL, D1, D0);
    step();
    check_now("illegal_hold_data", D1, D0);
    #1;
    set_in(N, N, N, N);
    push_exp(N, N);
    step();
    set_in(D0, IL, D1, D1);
    step();
    step();
    check_now("illegal_hold_null", N, N);
    #1;

    // Reset mid-wavefront clears DATA outputs.
    set_in(D1, D1, D1, D1);
    push_exp(D0, D1);
    step();
    rst = 1'b1;
    push_exp(N, N);
    step();
    set_in(N, N, N, N);
    step();
    rst = 1'b0;
    step();
    check_now("post_reset_null", N, N);

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_wavefronts: got %0d outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ncl_controller.md
# ncl_controller

Dual-rail (NULL Convention Logic style) control decoder for the phase sequencer. It combines two phase indicators (PH0, PH1) with read (Rd) and load (Ld) requests into two dual-rail enables: R_c (clear/capture register select) and R_m (memory register select). The outputs are registered in the single clock domain and follow NCL wavefront semantics: a DATA result is produced only from complete DATA inputs, and outputs return to NULL only after complete NULL inputs.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PH0_t, PH0_f  in  1 each  dual-rail phase 0.
- PH1_t, PH1_f  in  1 each  dual-rail phase 1.
- Rd_t, Rd_f  in  1 each  dual-rail read request.
- Ld_t, Ld_f  in  1 each  dual-rail load request.
- R_c_t, R_c_f  out  1 each  dual-rail R_c result.
- R_m_t, R_m_f  out  1 each  dual-rail R_m result.
- Port order after clk, rst: PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f, R_c_t, R_c_f, R_m_t, R_m_f.

## Operation
- Rail encoding per signal (t,f): 00 = NULL, 01 = DATA 0, 10 = DATA 1, 11 = illegal.
- Input set classification each cycle:
  - complete DATA: all four pairs are 01 or 10.
  - complete NULL: all eight rails are 0.
  - otherwise incomplete: partial, mixed, or containing any 11.
- Logic functions, evaluated on DATA values:
  - R_c = PH1 & ~PH0 & Rd
  - R_m = PH0 | (PH1 & Ld)
- Output state update:
  - Outputs NULL and inputs complete DATA: load encoded R_c and R_m. Each output is exactly one-hot (01 or 10).
  - Outputs DATA and inputs complete NULL: both outputs go to 00.
  - All other cases hold the current outputs (hysteresis). This includes:
    - incomplete inputs;
    - any illegal 11 pair;
    - DATA→DATA input changes without an intervening NULL;
    - NULL inputs while the outputs are already NULL.
- The two outputs always change together. No state exists where one output is DATA and the other is NULL.
- Outputs never show 11.

## Timing
- Reset value: R_c_t=R_c_f=R_m_t=R_m_f=0 (both outputs NULL).
- Reset has priority over every other condition, including reset asserted mid-wavefront.
- Latency: 1 clock from a complete input wavefront to the matching output wavefront. Outputs are registered and glitch-free.
- Complete DATA arriving in the same cycle reset deasserts is not captured. It is captured on the first clock with rst=0.
- Throughput: one DATA/NULL cycle pair per 2 clocks minimum.

## Structure
- Shared package `ncl_pkg`:
  - localparams DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10.
  - functions `dr_is_data`, `dr_is_null`, `dr_val`, `dr_enc`.
- Natural sub-module: `ncl_dr_reg`, a 2-rail register with hysteresis. It has a set input (complete DATA and encoded value), a clear input (complete NULL), and sync reset. It is instantiated once per output.
- The completion detection and function logic sit in the top module.

## Test plan
- Reset: assert rst with DATA inputs applied -> outputs 00/00. Release rst -> outputs load DATA one clock later.
- Exhaustive truth table: for each of the 16 input combinations, first apply all-NULL, then DATA. Required responses:
  - R_c=1 only for PH0=0, PH1=1, Rd=1 (both Ld values); R_c=0 otherwise.
  - R_m=1 for PH0=1 (all 8 combinations) and for PH0=0, PH1=1, Ld=1; R_m=0 otherwise.
- NULL return: from DATA outputs, apply all rails 0 -> both outputs 00 after one clock.
- Partial wavefront: from NULL state, drive only PH0 and PH1 DATA -> outputs stay 00. Complete Rd and Ld -> DATA appears next clock.
- Hysteresis: with outputs DATA (PH0=0, PH1=1, Rd=1, Ld=0 -> R_c=10, R_m=01), change Rd to 0 without NULL -> outputs unchanged. Then remove only some inputs to NULL -> outputs unchanged.
- Illegal encoding: drive PH1=11 with the other pairs DATA -> outputs hold their prior value and never show 11.
